sdp_scan_ctrl: RTL and testbench
================================

// Module: sdp_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for a multi-digit common-anode seven-segment display.
//   Holds one hex nibble, dp bit and enable bit per digit, and walks the digits round-robin.
//   Each digit slot is a fixed-length time slot with a leading blanking guard against ghosting.
//   Drives the active-low anode lines; feeds the current nibble to the hex-to-segment decoder
//   and the dp bit to the top level. Display data is double-buffered and commits only at frame boundaries.
// PARAMETERS
//   DIGITS        8       number of digits scanned, 1..8
//   REFRESH_DIV   100000  clock cycles per digit slot, >= 2
//   BLANK_CYCLES  1000    cycles at slot start with all anodes off, 1..REFRESH_DIV-1
// PORTS
//   clk         in   1          system clock, all logic on rising edge
//   rst         in   1          synchronous, active-high reset
//   load        in   1          1-cycle strobe: capture data_in/dp_in/en_in into pending buffer
//   data_in     in   4*DIGITS   nibble per digit, digit k = data_in[4k+3:4k]
//   dp_in       in   DIGITS     decimal point per digit, 1 = lit
//   en_in       in   DIGITS     digit enable, 0 = digit kept dark for its slot
//   load_ack    out  1          1-cycle pulse, cycle after load accepted
//   frame_done  out  1          1-cycle pulse when last digit slot ends
//   an          out  DIGITS     anode drive, active-low, at most one bit low
//   nibble      out  4          nibble of current digit, to hex-to-segment decoder
//   dp          out  1          dp of current digit, 1 = lit (top level inverts onto seg[7])
//   digit_idx   out  clog2(DIGITS) (min 1)  index of current slot
// BEHAVIOUR
//   - State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..DIGITS-1),
//     active buffer {data,dp,en}, pending buffer {data,dp,en}, pend_valid flag.
//   - Phases within a slot: BLANK while cnt < BLANK_CYCLES; SHOW otherwise.
//   - Every cycle cnt increments. At cnt == REFRESH_DIV-1: cnt <= 0 and idx advances.
//     idx == DIGITS-1 wraps to 0 (frame boundary).
//   - At a frame boundary:
//       - frame_done pulses for one cycle.
//       - If pend_valid: active <= pending, pend_valid <= 0.
//       - The new frame starts on the new data.
//   - load: pending <= inputs, pend_valid <= 1, load_ack = 1 next cycle. Accepted on every cycle.
//     Back-to-back loads: last one wins. No effect on the active buffer mid-frame (no tearing).
//   - load on the frame-boundary cycle:
//       - The commit takes the OLD pending contents.
//       - The new values enter pending with pend_valid kept at 1; they commit at the next boundary.
//   - Disabled digits (active en[k] = 0) still consume their full slot (constant refresh rate);
//     an stays all-ones for that slot.
//   - Registered outputs: an, nibble, dp, digit_idx reflect the cnt/idx of the previous cycle
//     (1-cycle latency).
//       - SHOW: an = ~(en[idx] << idx).
//       - BLANK: an = all ones.
//       - nibble/dp = active entry [idx] in both phases.
//   - Reset values:
//       - cnt = 0, idx = 0, active and pending buffers all zero, pend_valid = 0.
//       - an = all ones, nibble = 0, dp = 0, digit_idx = 0, load_ack = 0, frame_done = 0.
//   - Reset mid-frame: takes effect next edge. Pending data and in-flight loads are lost; scan restarts at digit 0.
//   - rst has priority over load on the same cycle.
//   - Widths: cnt is clog2(REFRESH_DIV) bits; no arithmetic on the data path; nibble passed unmodified.
// TESTING  (DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 unless noted)
//   - Reset, no load -> an = 4'b1111 throughout; frame_done pulses every 32 cycles; digit_idx 0,1,2,3,0.
//   - load data_in=16'h3A71, en_in=4'hF at cycle 5 -> load_ack at cycle 6; first boundary commits.
//     Next frame: nibble 1,7,A,3. For each slot: an 1111 for 2 cycles, then 1110/1101/1011/0111 for 6.
//   - Mid-frame load 16'hFFFF during digit 1 of a frame showing 16'h3A71 -> remaining digits still show 7,A,3.
//     16'hFFFF appears only after frame_done.
//   - load on exact boundary cycle, pending already 16'h1111 -> next frame 16'h1111; following frame the new value.
//   - en_in=4'b0101, dp_in=4'b0100 -> an never low for digits 1,3; dp=1 only while digit_idx=2; slot timing unchanged.
//   - rst asserted during SHOW of digit 2 with a pending load -> next cycle an=1111, digit_idx=0;
//     the pending load never commits.

Source files
------------

// File: rtl/sdp_scan_ctrl.sv
// sdp_scan_ctrl: round-robin scan controller for a multi-digit common-anode seven-segment display
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   load                1-cycle strobe capturing data_in/dp_in/en_in into the pending buffer
//   data_in/dp_in/en_in per-digit nibble, decimal point and enable (digit k at data_in[4k+3:4k])
//   load_ack            pulse the cycle after a load is accepted
//   frame_done          pulse as the last digit slot of a frame ends
//   an                  active-low anodes, at most one bit low
//   nibble/dp/digit_idx current digit's nibble, decimal point and index (registered)
module sdp_scan_ctrl #(
  parameter int DIGITS = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYCLES = 1000,
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1,
  localparam int CW = $clog2(REFRESH_DIV)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     en_in,
  output logic                  load_ack,
  output logic                  frame_done,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            nibble,
  output logic                  dp,
  output logic [IW-1:0]         digit_idx
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [DIGITS-1:0] act_dp_q, act_dp_d, act_en_q, act_en_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d, pend_en_q, pend_en_d;
  logic pv_q, pv_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0] nib_q, nib_d;
  logic dp_q, dp_d, ack_q, fd_q, fd_d;
  logic [IW-1:0] didx_q;
  logic slot_end, frame_end, commit;
  always_comb begin
    slot_end = cnt_q == CW'(REFRESH_DIV - 1);
    frame_end = slot_end && idx_q == IW'(DIGITS - 1);
    // a load landing on the boundary cycle still commits the older pending contents
    commit = frame_end && pv_q;
    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = frame_end ? '0 : slot_end ? idx_q + IW'(1) : idx_q;
    act_data_d = commit ? pend_data_q : act_data_q;
    act_dp_d = commit ? pend_dp_q : act_dp_q;
    act_en_d = commit ? pend_en_q : act_en_q;
    pend_data_d = load ? data_in : pend_data_q;
    pend_dp_d = load ? dp_in : pend_dp_q;
    pend_en_d = load ? en_in : pend_en_q;
    pv_d = load | (pv_q & ~frame_end);
    an_d = cnt_q < CW'(BLANK_CYCLES) ? '1 : ~(DIGITS'(act_en_q[idx_q]) << idx_q);
    nib_d = act_data_q[{idx_q, 2'b00} +: 4];
    dp_d = act_dp_q[idx_q];
    fd_d = frame_end;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      act_data_q <= '0;
      act_dp_q <= '0;
      act_en_q <= '0;
      pend_data_q <= '0;
      pend_dp_q <= '0;
      pend_en_q <= '0;
      pv_q <= 1'b0;
      an_q <= '1;
      nib_q <= '0;
      dp_q <= 1'b0;
      didx_q <= '0;
      ack_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      act_data_q <= act_data_d;
      act_dp_q <= act_dp_d;
      act_en_q <= act_en_d;
      pend_data_q <= pend_data_d;
      pend_dp_q <= pend_dp_d;
      pend_en_q <= pend_en_d;
      pv_q <= pv_d;
      an_q <= an_d;
      nib_q <= nib_d;
      dp_q <= dp_d;
      didx_q <= idx_q;
      ack_q <= load;
      fd_q <= fd_d;
    end
  end
  assign an = an_q;
  assign nibble = nib_q;
  assign dp = dp_q;
  assign digit_idx = didx_q;
  assign load_ack = ack_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_sdp_scan_ctrl.sv
// tb_sdp_scan_ctrl: scoreboard bench for sdp_scan_ctrl with DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2
module tb_sdp_scan_ctrl;
  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nib;
    logic dp;
    logic [1:0] idx;
    logic fd;
    logic ack;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0] dp_in = '0;
  logic [3:0] en_in = '0;
  logic load_ack, frame_done, dp;
  logic [3:0] an, nibble;
  logic [1:0] digit_idx;
  exp_t q[$];
  exp_t rst_x;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  sdp_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in), .en_in(en_in),
    .load_ack(load_ack), .frame_done(frame_done), .an(an), .nibble(nibble), .dp(dp),
    .digit_idx(digit_idx)
  );
  function automatic exp_t slot_exp(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p,
                                    input int o, input logic a);
    exp_t x;
    int k;
    int c;
    k = o / 8;
    c = o % 8;
    x.an = (c < 2 || !e[k]) ? 4'hF : ~(4'b0001 << k);
    x.nib = d[4*k +: 4];
    x.dp = p[k];
    x.idx = 2'(k);
    x.fd = o == 31;
    x.ack = a;
    return x;
  endfunction
  task automatic step(input logic r, input logic l, input logic [15:0] d, input logic [3:0] e,
                      input logic [3:0] p, input exp_t x);
    @(negedge clk);
    rst = r;
    load = l;
    data_in = d;
    en_in = e;
    dp_in = p;
    q.push_back(x);
  endtask
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, '0, rst_x);
  endtask
  task automatic frame(input logic [15:0] sd, input logic [3:0] se, input logic [3:0] sp, input int n,
                       input int o1, input logic [15:0] d1, input logic [3:0] e1, input logic [3:0] p1,
                       input int o2, input logic [15:0] d2, input logic [3:0] e2, input logic [3:0] p2);
    logic l, l2;
    for (int o = 0; o < n; o++) begin
      l2 = o == o2;
      l = l2 || o == o1;
      step(1'b0, l, l2 ? d2 : d1, l2 ? e2 : e1, l2 ? p2 : p1, slot_exp(sd, se, sp, o, l));
    end
  endtask
  initial begin
    exp_t x, got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        got = '{an, nibble, dp, digit_idx, frame_done, load_ack};
        tests++;
        if (got !== x) begin
          fails++;
          $display("FAIL chk%0d {an,nibble,dp,idx,fd,ack} got %b %h %b %0d %b %b need %b %h %b %0d %b %b",
                   tests, got.an, got.nib, got.dp, got.idx, got.fd, got.ack,
                   x.an, x.nib, x.dp, x.idx, x.fd, x.ack);
        end
      end
    end
  end
  initial begin
    rst_x = '{an: 4'hF, nib: 4'h0, dp: 1'b0, idx: 2'd0, fd: 1'b0, ack: 1'b0};
    do_reset(3);
    frame(16'h0000, 4'h0, 4'h0, 32, 5, 16'h3A71, 4'hF, 4'h0, -1, '0, '0, '0);
    frame(16'h3A71, 4'hF, 4'h0, 32, 9, 16'hFFFF, 4'hF, 4'h0, -1, '0, '0, '0);
    frame(16'hFFFF, 4'hF, 4'h0, 32, 10, 16'h1111, 4'hF, 4'h0, 31, 16'h2468, 4'hF, 4'hF);
    frame(16'h1111, 4'hF, 4'h0, 32, -1, '0, '0, '0, -1, '0, '0, '0);
    frame(16'h2468, 4'hF, 4'hF, 32, 3, 16'h9C5E, 4'b0101, 4'b0100, -1, '0, '0, '0);
    frame(16'h9C5E, 4'b0101, 4'b0100, 32, 4, 16'hABCD, 4'hF, 4'h0, 5, 16'h4321, 4'hF, 4'b0001);
    frame(16'h4321, 4'hF, 4'b0001, 22, 20, 16'h7777, 4'hF, 4'h0, -1, '0, '0, '0);
    do_reset(2);
    frame(16'h0000, 4'h0, 4'h0, 32, -1, '0, '0, '0, -1, '0, '0, '0);
    frame(16'h0000, 4'h0, 4'h0, 32, -1, '0, '0, '0, -1, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending_entries got %0d need 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
